// File: rtl/axi_burst_writer.sv
// axi_burst_writer
//   AXI4 write master. Takes a command (start byte address + word count) and a
//   valid/ready data stream and emits INCR bursts on AW/W/B, one burst
//   outstanding at a time, each at most MAX_BURST_LEN beats.
//
//   Optional feature macro: AXI_BURST_WRITER_4K_SPLIT_EN
//     defined   -> bursts are additionally clipped so they never cross a 4 KiB
//                  boundary (requires ADDR_WIDTH >= 12)
//     undefined -> callers guarantee no command crosses a 4 KiB boundary
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cmd_addr/cmd_len           command (byte address, word count, 0 allowed)
//   cmd_valid/cmd_ready        command handshake
//   s_data/s_valid/s_ready     write data stream (passed straight onto W)
//   done_valid/done_err        one-cycle completion pulse, sticky bresp error
//   m_axi_aw*                  AXI write address channel
//   m_axi_w*                   AXI write data channel
//   m_axi_b*                   AXI write response channel (bid ignored)
module axi_burst_writer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  done_valid,
  output logic                  done_err,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int SHIFT = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << SHIFT;

  typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;      // start of current/next burst
  logic [15:0]           remaining, rem_nxt;  // words not yet covered by a finished burst
  logic [8:0]            beats, beats_nxt;    // length of current/next burst
  logic [8:0]            beat_cnt;            // W beats left in current burst
  logic [7:0]            awlen_q;
  logic                  err;
  logic                  w_hs;

  // Response ID is not checked: only one burst is ever outstanding.
  logic unused_bid;
  assign unused_bid = ^m_axi_bid;

  assign w_hs = m_axi_wvalid & m_axi_wready;

  // Next burst geometry: from the command in IDLE, from the advanced
  // address/remaining count in B. Only latched on those transitions.
  always_comb begin
    addr_nxt = addr + (ADDR_WIDTH'(beats) << SHIFT);
    rem_nxt  = remaining - 16'(beats);
    if (state == IDLE) begin
      addr_nxt = cmd_addr & ALIGN_MASK;
      rem_nxt  = cmd_len;
    end
    beats_nxt = (rem_nxt > 16'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : rem_nxt[8:0];
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
    begin
      logic [12:0] to_4k;
      to_4k = (13'h1000 - {1'b0, addr_nxt[11:0]}) >> SHIFT;
      if (to_4k < {4'b0, beats_nxt}) beats_nxt = to_4k[8:0];
    end
`endif
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    s_ready       = 1'b0;
    m_axi_bready  = 1'b0;
    done_valid    = 1'b0;
    done_err      = 1'b0;
    case (state)
      IDLE: begin
        // state already reads IDLE during reset; keep the handshake closed
        cmd_ready = rst_n;
        if (cmd_valid) state_nxt = (cmd_len == 16'd0) ? DONE : AW;
      end
      AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = W;
      end
      W: begin
        m_axi_wvalid = s_valid;
        s_ready      = m_axi_wready;
        m_axi_wlast  = (beat_cnt == 9'd1);
        if (s_valid && m_axi_wready && beat_cnt == 9'd1) state_nxt = B;
      end
      B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = (rem_nxt != 16'd0) ? AW : DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        done_err   = err;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      beats     <= '0;
      beat_cnt  <= '0;
      awlen_q   <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (cmd_valid) begin
          addr      <= addr_nxt;
          remaining <= rem_nxt;
          err       <= 1'b0;
          if (cmd_len != 16'd0) begin
            beats   <= beats_nxt;
            awlen_q <= 8'(beats_nxt - 9'd1);
          end
        end
        AW: if (m_axi_awready) beat_cnt <= beats;
        W:  if (w_hs) beat_cnt <= beat_cnt - 9'd1;
        B: if (m_axi_bvalid) begin
          // error responses are recorded but never abort the command
          err       <= err | (m_axi_bresp != 2'b00);
          addr      <= addr_nxt;
          remaining <= rem_nxt;
          if (rem_nxt != 16'd0) begin
            beats   <= beats_nxt;
            awlen_q <= 8'(beats_nxt - 9'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(SHIFT);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0000;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = {STRB_WIDTH{1'b1}};

endmodule

// File: tb/tb_axi_burst_writer.sv
// tb_axi_burst_writer
//   Directed bench for axi_burst_writer with a small behavioural AXI write
//   slave (always ready, word memory, one B per burst, selectable error burst)
//   and an always-valid incrementing data source.
module tb_axi_burst_writer;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int IW = 8;
  localparam logic [31:0] DBASE = 32'hC0DE_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cmd_addr;
  logic [15:0]   cmd_len;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready;
  logic          done_valid, done_err;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awlock;
  logic [3:0]    awcache;
  logic [2:0]    awprot;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid, bready;

  always #5 clk = ~clk;

  axi_burst_writer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .done_valid(done_valid), .done_err(done_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  // ---------------- slave model / logging ----------------
  int          checks = 0, failures = 0;
  int          cyc = 0, aw_total = 0, w_total = 0, done_total = 0, done_cyc = 0;
  int          data_idx = 0, beat_in_burst = 0, err_burst = -1;
  logic [15:0] aw_addr_log [64];
  logic [7:0]  aw_len_log  [64];
  int          aw_cyc_log  [64];
  int          b_cyc_log   [64];
  int          last_beat_log [64];
  logic [15:0] w_addr;
  logic [31:0] mem [0:16383];

  assign s_data = DBASE + 32'(data_idx);
  assign bid    = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (awvalid && awready) begin
      aw_addr_log[aw_total] <= awaddr;
      aw_len_log[aw_total]  <= awlen;
      aw_cyc_log[aw_total]  <= cyc;
      aw_total      <= aw_total + 1;
      w_addr        <= awaddr;
      beat_in_burst <= 0;
    end
    if (wvalid && wready) begin
      mem[w_addr[15:2]] <= wdata;
      w_addr        <= w_addr + 16'd4;
      beat_in_burst <= beat_in_burst + 1;
      w_total       <= w_total + 1;
      if (wlast) last_beat_log[aw_total-1] <= beat_in_burst + 1;
    end
    if (bvalid && bready) b_cyc_log[aw_total-1] <= cyc;
    if (s_valid && s_ready) data_idx <= data_idx + 1;
    if (done_valid) begin
      done_cyc   <= cyc;
      done_total <= done_total + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid <= 1'b0;
      bresp  <= 2'b00;
    end else if (wvalid && wready && wlast) begin
      bvalid <= 1'b1;
      bresp  <= (aw_total - 1 == err_burst) ? 2'b10 : 2'b00;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
      bresp  <= 2'b00;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a command, returns at the negedge of the cycle after acceptance.
  task automatic issue(input logic [15:0] a, input logic [15:0] n);
    cmd_addr  = a;
    cmd_len   = n;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Full command with generic completion checks; a0 = first AW log index.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] n,
                     input logic exp_err, output int a0);
    int   d0;
    logic got, err;
    a0  = aw_total;
    d0  = done_total;
    got = 1'b0;
    err = 1'b0;
    issue(a, n);
    chk({tag, "_awvalid_n1"}, awvalid, (n != 0));
    for (int i = 0; i < 2000; i++) begin
      if (done_valid) begin
        got = 1'b1;
        err = done_err;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_done_err"}, err, exp_err);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done_valid, 0);
    chk({tag, "_done_count"}, done_total, d0 + 1);
    if (n != 0) chk({tag, "_done_after_b"}, done_cyc, b_cyc_log[aw_total-1] + 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0, d0, w0, base, mism;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    s_valid   = 1'b1;
    awready   = 1'b1;
    wready    = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // single short burst
    base = data_idx;
    run("t1", 16'h0100, 16'd4, 1'b0, a0);
    chk("t1_aw_count", aw_total - a0, 1);
    chk("t1_awaddr", aw_addr_log[a0], 16'h0100);
    chk("t1_awlen", aw_len_log[a0], 3);
    chk("t1_wlast_beat", last_beat_log[a0], 4);
    chk("t1_mem0", mem[16'h0040], DBASE + 32'(base));
    chk("t1_mem3", mem[16'h0043], DBASE + 32'(base + 3));
    chk("awsize", awsize, 2);
    chk("awburst", awburst, 1);
    chk("wstrb", wstrb, 4'hF);
    chk("awid", awid, 0);
    chk("aw_lock_cache_prot", {awlock, awcache, awprot}, 0);

    // 40 words split into 16/16/8
    base = data_idx;
    run("t2", 16'h0000, 16'd40, 1'b0, a0);
    chk("t2_aw_count", aw_total - a0, 3);
    chk("t2_awaddr0", aw_addr_log[a0], 16'h0000);
    chk("t2_awlen0", aw_len_log[a0], 15);
    chk("t2_awaddr1", aw_addr_log[a0+1], 16'h0040);
    chk("t2_awlen1", aw_len_log[a0+1], 15);
    chk("t2_awaddr2", aw_addr_log[a0+2], 16'h0080);
    chk("t2_awlen2", aw_len_log[a0+2], 7);
    chk("t2_wlast_beat0", last_beat_log[a0], 16);
    chk("t2_wlast_beat2", last_beat_log[a0+2], 8);
    chk("t2_aw_after_b", aw_cyc_log[a0+1], b_cyc_log[a0] + 1);
    mism = 0;
    for (int i = 0; i < 40; i++)
      if (mem[i] !== DBASE + 32'(base + i)) mism++;
    chk("t2_readback_mismatches", mism, 0);

    // 4 KiB boundary
    run("t3", 16'h0FF8, 16'd8, 1'b0, a0);
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
    chk("t3_aw_count", aw_total - a0, 2);
    chk("t3_awaddr0", aw_addr_log[a0], 16'h0FF8);
    chk("t3_awlen0", aw_len_log[a0], 1);
    chk("t3_awaddr1", aw_addr_log[a0+1], 16'h1000);
    chk("t3_awlen1", aw_len_log[a0+1], 5);
`else
    chk("t3_aw_count", aw_total - a0, 1);
    chk("t3_awaddr0", aw_addr_log[a0], 16'h0FF8);
    chk("t3_awlen0", aw_len_log[a0], 7);
`endif

    // error response on second burst does not abort
    err_burst = aw_total + 1;
    run("t4", 16'h0400, 16'd40, 1'b1, a0);
    err_burst = -1;
    chk("t4_aw_count", aw_total - a0, 3);
    chk("t4_awaddr2", aw_addr_log[a0+2], 16'h0480);
    chk("t4_awlen2", aw_len_log[a0+2], 7);

    // next command clears the sticky error
    run("t4b", 16'h0500, 16'd2, 1'b0, a0);
    chk("t4b_awlen", aw_len_log[a0], 1);

    // zero-length command
    a0 = aw_total;
    issue(16'h0600, 16'd0);
    chk("t5_done_next_cycle", done_valid, 1);
    chk("t5_done_err", done_err, 0);
    chk("t5_awvalid", awvalid, 0);
    @(negedge clk);
    chk("t5_done_one_cycle", done_valid, 0);
    chk("t5_no_aw", aw_total - a0, 0);

    // reset in the middle of a burst
    d0 = done_total;
    w0 = w_total;
    issue(16'h0200, 16'd4);
    for (int i = 0; i < 50 && w_total != w0 + 2; i++) @(negedge clk);
    chk("t6_two_beats_seen", w_total, w0 + 2);
    rst_n = 1'b0;
    #1;
    chk("t6_wvalid", wvalid, 0);
    chk("t6_awvalid", awvalid, 0);
    chk("t6_bready", bready, 0);
    chk("t6_s_ready", s_ready, 0);
    chk("t6_cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_cmd_ready_after", cmd_ready, 1);
    chk("t6_no_done", done_total, d0);
    base = data_idx;
    run("t6b", 16'h0300, 16'd1, 1'b0, a0);
    chk("t6b_awaddr", aw_addr_log[a0], 16'h0300);
    chk("t6b_awlen", aw_len_log[a0], 0);
    chk("t6b_wlast_beat", last_beat_log[a0], 1);
    chk("t6b_mem", mem[16'h00C0], DBASE + 32'(base));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard stop in case something stalls outside the bounded waits
  initial begin
    #200000;
    $display("FAIL global_timeout observed=stalled expected=finish");
    $fatal(1, "timeout");
  end
endmodule
